// File: rtl/tick_scheduler.sv
// ---------------------------------------------------------------------------
// tick_scheduler
//
// Shares one free-running prescaler between NUM_CH timer channels. The
// prescaler emits a one-cycle base_tick every PRE_DIV clocks. Each channel,
// once started, counts base ticks and emits a one-cycle tick_out pulse every
// `period` base ticks (periodic mode) or exactly once (one-shot mode).
// Consumers use tick_out as a clock enable inside the single clk domain.
//
// Ports:
//   clk         system clock
//   rst_n       synchronous active-low reset
//   cmd_valid   command present
//   cmd_ready   command may be accepted this cycle (low on base_tick cycles)
//   cmd_op      00 NOP, 01 START_PERIODIC, 10 START_ONESHOT, 11 STOP
//   cmd_ch      target channel
//   cmd_period  period in base ticks (START opcodes only)
//   cmd_err     one-cycle pulse after a rejected START command
//   base_tick   one-cycle prescaler pulse
//   tick_out    per-channel one-cycle tick pulse
//   busy        per-channel RUN indication
// ---------------------------------------------------------------------------
module tick_scheduler #(
   parameter int PRE_DIV = 2097152,
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int CH_W    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [CNT_W-1:0]  cmd_period,
   output logic              cmd_err,
   output logic              base_tick,
   output logic [NUM_CH-1:0] tick_out,
   output logic [NUM_CH-1:0] busy
);

   localparam int              PRE_W    = $clog2(PRE_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

   localparam logic [1:0] OP_NOP       = 2'b00;
   localparam logic [1:0] OP_START_PER = 2'b01;
   localparam logic [1:0] OP_START_ONE = 2'b10;
   localparam logic [1:0] OP_STOP      = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   logic [PRE_W-1:0] pre_cnt;
   ch_state_t        state   [NUM_CH];
   logic [CNT_W-1:0] per     [NUM_CH];
   logic [CNT_W-1:0] rem     [NUM_CH];
   logic [NUM_CH-1:0] oneshot;

   logic cmd_accept;
   logic is_start;
   logic ch_ok;
   logic start_bad;
   logic start_good;
   logic stop_cmd;

   // The base tick is decoded straight from the prescaler register so it
   // lines up with the cycle in which the counter holds its last value.
   assign base_tick = (pre_cnt == PRE_LAST);

   // Commands are held off on base_tick cycles, so a command can never
   // collide with a channel count update in the same cycle.
   assign cmd_ready  = rst_n & ~base_tick;
   assign cmd_accept = cmd_valid & cmd_ready;

   // Command decode. Only START opcodes are ever rejected; a STOP aimed at a
   // channel that does not exist simply matches nothing below.
   assign is_start   = (cmd_op == OP_START_PER) | (cmd_op == OP_START_ONE);
   assign ch_ok      = (32'(cmd_ch) < NUM_CH);
   assign start_bad  = cmd_accept & is_start & ((cmd_period == '0) | ~ch_ok);
   assign start_good = cmd_accept & is_start & (cmd_period != '0) & ch_ok;
   assign stop_cmd   = cmd_accept & (cmd_op == OP_STOP);

   // busy is a direct view of the registered channel state.
   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (state[i] == RUN);
      end
   end

   // Prescaler, command handling and all channel FSMs live in one clocked
   // process. rem reloads from per when it reaches 1, so in RUN it never
   // reaches 0 and never wraps. tick_out is cleared every cycle and only set
   // for the cycle right after the base tick that expires a channel.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre_cnt  <= '0;
         cmd_err  <= 1'b0;
         tick_out <= '0;
         oneshot  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            state[i] <= IDLE;
            rem[i]   <= '0;
            per[i]   <= '0;
         end
      end else begin
         pre_cnt  <= base_tick ? '0 : pre_cnt + 1'b1;
         cmd_err  <= start_bad;
         tick_out <= '0;

         for (int i = 0; i < NUM_CH; i++) begin
            if (base_tick && (state[i] == RUN)) begin
               if (rem[i] == CNT_W'(1)) begin
                  tick_out[i] <= 1'b1;
                  if (oneshot[i]) begin
                     state[i] <= IDLE;
                     rem[i]   <= '0;
                  end else begin
                     rem[i] <= per[i];
                  end
               end else begin
                  rem[i] <= rem[i] - 1'b1;
               end
            end

            // A START restarts from the full count even when already running.
            if (start_good && (cmd_ch == CH_W'(i))) begin
               per[i]     <= cmd_period;
               rem[i]     <= cmd_period;
               oneshot[i] <= (cmd_op == OP_START_ONE);
               state[i]   <= RUN;
            end

            if (stop_cmd && (cmd_ch == CH_W'(i))) begin
               state[i] <= IDLE;
               rem[i]   <= '0;
            end
         end
      end
   end

endmodule
